amp_power_sequencer: RTL and testbench
======================================

AMP_POWER_SEQUENCER -- requirements
Module: amp_power_sequencer

Interface
REQ-001 The block SHALL have parameter WAKE_CYCLES, default 1000000, meaning the wake-up wait from SHUTDOWN rise to audio_en rise (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 1000, meaning the mute settle time before and after a gain change.
REQ-003 The block SHALL have parameter IDLE_CYCLES, default 100000000, meaning the number of cycles without activity before auto-shutdown.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: system permission for the amplifier to run.
REQ-007 The block SHALL have port activity, input, 1 bit: one-cycle pulse per audio sample presented to the PWM path.
REQ-008 The block SHALL have port gain_sel, input, 2 bits: requested amplifier gain code.
REQ-009 The block SHALL have port gain_wr, input, 1 bit: one-cycle strobe that captures gain_sel.
REQ-010 The block SHALL have port GAIN, output, 2 bits: PmodAMP2 gain pins.
REQ-011 The block SHALL have port SHUTDOWN, output, 1 bit: PmodAMP2 SD pin, where 1 = amplifier running and 0 = shut down.
REQ-012 The block SHALL have port audio_en, output, 1 bit: permits the PWM datapath to drive audio; 0 forces silence.
REQ-013 The block SHALL have port busy, output, 1 bit: 1 in WAKE, MUTE and UNMUTE.

Function
REQ-014 The block SHALL register all outputs, and SHALL decode them from the registered state only.
REQ-015 The block SHALL use states OFF, WAKE, ACTIVE, MUTE and UNMUTE. Outputs per state (SHUTDOWN / audio_en): OFF 0/0; WAKE 1/0; ACTIVE 1/1; MUTE 1/0; UNMUTE 1/0.
REQ-016 In OFF, when enable=1 and activity=1 in the same cycle, the block SHALL go to WAKE; SHUTDOWN rises on the next edge.
REQ-017 In WAKE, the block SHALL go to ACTIVE after exactly WAKE_CYCLES cycles, so audio_en rises WAKE_CYCLES cycles after SHUTDOWN rises.
REQ-018 In ACTIVE, the idle counter SHALL clear on activity and increment otherwise; on reaching IDLE_CYCLES-1 without activity, the block SHALL go to OFF.
REQ-019 If activity coincides with idle expiry, activity SHALL win: the counter clears and the block stays in ACTIVE.
REQ-020 In ACTIVE, with a gain pending, the block SHALL go to MUTE.
REQ-021 The block SHALL remain in MUTE for SETTLE_CYCLES cycles, then load GAIN from the pending register, clear pending and go to UNMUTE.
REQ-022 The block SHALL remain in UNMUTE for SETTLE_CYCLES cycles, then go to ACTIVE.
REQ-023 A gain_wr SHALL be captured into the pending register in any state, with the last write winning.
REQ-024 A gain_wr whose code equals both the current GAIN and the pending value SHALL be ignored.
REQ-025 In OFF, a gain_wr SHALL update GAIN on the next edge without muting, and SHALL leave nothing pending.
REQ-026 A gain_wr received during UNMUTE SHALL leave pending set, so the block returns to ACTIVE for one cycle and then re-enters MUTE.
REQ-027 In WAKE, a pending gain SHALL be applied to GAIN at the WAKE-to-ACTIVE transition with no mute cycle, since audio_en is still 0.
REQ-028 enable=0 SHALL have priority over every other condition: from any state, the block goes to OFF on the next edge, with audio_en and SHUTDOWN falling together.
REQ-029 Any pending gain SHALL be kept through a forced OFF caused by enable=0.
REQ-030 The idle counter and the settle/wake timer SHALL be unsigned, sized $clog2(max parameter)+1 bits, and SHALL never wrap; they saturate or stop at terminal count.
REQ-031 GAIN SHALL never change while audio_en=1.

Reset
REQ-032 While rst=0, the block SHALL hold state OFF, GAIN=2'b00, SHUTDOWN=0, audio_en=0, busy=0, pending clear and both counters at 0; assertion takes effect asynchronously.
REQ-033 Deassertion of rst SHALL be synchronised to clk, and the first state change SHALL occur no earlier than the second clk edge after release.
REQ-034 If rst asserts mid-WAKE or mid-MUTE, the block SHALL drop all outputs immediately, and the interrupted gain change SHALL be discarded.

Structure
REQ-035 Package amp_ctrl_pkg SHALL hold the state enum, the gain code enum (GAIN_0..GAIN_3) and the output decode constants.
REQ-036 Sub-module amp_ctrl_timer SHALL be a loadable down-counter with a done flag, used for both WAKE and SETTLE waits; the idle counter stays in the top module.

Verification (bench parameters WAKE_CYCLES=8, SETTLE_CYCLES=4, IDLE_CYCLES=20)
REQ-037 Scenario: enable=1, single activity pulse -> SHUTDOWN=1 one cycle later, audio_en=1 exactly 8 cycles after that, busy=1 throughout WAKE.
REQ-038 Scenario: in ACTIVE, gain_wr with gain_sel=2'b10 -> audio_en=0 next cycle, GAIN=2'b10 after 4 cycles, audio_en=1 after a further 4 cycles, with GAIN never changing while audio_en=1.
REQ-039 Scenario: in ACTIVE, no activity for 20 cycles -> OFF, SHUTDOWN=0; activity on cycle 19 -> remains ACTIVE.
REQ-040 Scenario: gain_wr 2'b01 in MUTE, then 2'b11 in UNMUTE -> GAIN=2'b01 first, then a second mute cycle ending with GAIN=2'b11.
REQ-041 Scenario: enable dropped mid-MUTE -> SHUTDOWN=0 and audio_en=0 next cycle, pending gain kept.
REQ-042 Scenario: rst low mid-WAKE -> outputs 0 asynchronously, GAIN=2'b00; after release, OFF until the next activity.

Source files
------------

// File: rtl/amp_ctrl_pkg.sv
// Shared types and output decode for the PmodAMP2 power sequencer.
package amp_ctrl_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_WAKE   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_MUTE   = 3'd3,
    ST_UNMUTE = 3'd4
  } amp_state_e;

  // Amplifier gain pin codes
  typedef enum logic [1:0] {
    GAIN_0 = 2'd0,
    GAIN_1 = 2'd1,
    GAIN_2 = 2'd2,
    GAIN_3 = 2'd3
  } amp_gain_e;

  // Control pins driven by the sequencer
  typedef struct packed {
    logic shutdown;
    logic audio_en;
    logic busy;
  } amp_out_t;

  localparam amp_out_t OUT_OFF    = '{shutdown: 1'b0, audio_en: 1'b0, busy: 1'b0};
  localparam amp_out_t OUT_WAKE   = '{shutdown: 1'b1, audio_en: 1'b0, busy: 1'b1};
  localparam amp_out_t OUT_ACTIVE = '{shutdown: 1'b1, audio_en: 1'b1, busy: 1'b0};
  localparam amp_out_t OUT_MUTE   = '{shutdown: 1'b1, audio_en: 1'b0, busy: 1'b1};
  localparam amp_out_t OUT_UNMUTE = '{shutdown: 1'b1, audio_en: 1'b0, busy: 1'b1};

  // Map a state onto its pin levels
  function automatic amp_out_t decode_outputs(amp_state_e s);
    amp_out_t o;
    o = OUT_OFF;
    case (s)
      ST_WAKE:   o = OUT_WAKE;
      ST_ACTIVE: o = OUT_ACTIVE;
      ST_MUTE:   o = OUT_MUTE;
      ST_UNMUTE: o = OUT_UNMUTE;
      default:   o = OUT_OFF;
    endcase
    return o;
  endfunction

  // Larger of two cycle counts, used to size the shared counters
  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/amp_ctrl_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module amp_ctrl_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q;

  // Load has priority; otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with a registered terminal flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == '0);
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/amp_power_sequencer.sv
// PmodAMP2 power/gain sequencer: wake delay, idle auto-shutdown and muted gain changes.
module amp_power_sequencer
  import amp_ctrl_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES   = 1000000,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned IDLE_CYCLES   = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       activity,
  input  logic [1:0] gain_sel,
  input  logic       gain_wr,
  output logic [1:0] GAIN,
  output logic       SHUTDOWN,
  output logic       audio_en,
  output logic       busy
);

  localparam int unsigned MAX_CYC = max_u(max_u(WAKE_CYCLES, SETTLE_CYCLES), IDLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] WAKE_LOAD   = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_CYCLES - 1);

  amp_state_e       state_q, state_d;
  amp_out_t         out_q, out_d;
  logic [1:0]       run_q;
  logic             run;
  logic [CNT_W-1:0] idle_q, idle_d;
  amp_gain_e        gain_q, gain_d;
  amp_gain_e        pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  amp_gain_e        sel_c;
  logic             wr_acc_c;
  logic             apply_c;
  logic             tmr_load_c;
  logic [CNT_W-1:0] tmr_val_c;
  logic             tmr_done;

  // Release is seen two edges after rst rises; nothing moves before then
  assign run = run_q[1];

  // A write is dropped only when it matches both the live and the pending code
  assign sel_c    = amp_gain_e'(gain_sel);
  assign wr_acc_c = run && gain_wr && !((sel_c == gain_q) && (sel_c == pend_val_q));

  // State and output pin registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_OFF;
      out_q   <= OUT_OFF;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Next-state: enable low wins everywhere, then per-state sequencing
  always_comb begin
    state_d = state_q;
    if (run) begin
      if (!enable) begin
        state_d = ST_OFF;
      end else begin
        case (state_q)
          ST_OFF: begin
            if (activity) state_d = ST_WAKE;
          end
          ST_WAKE: begin
            if (tmr_done) state_d = ST_ACTIVE;
          end
          ST_ACTIVE: begin
            if (pend_q || wr_acc_c) begin
              state_d = ST_MUTE;
            end else if (!activity && (idle_q == IDLE_LAST)) begin
              state_d = ST_OFF;
            end
          end
          ST_MUTE: begin
            if (tmr_done) state_d = ST_UNMUTE;
          end
          ST_UNMUTE: begin
            if (tmr_done) state_d = ST_ACTIVE;
          end
          default: state_d = ST_OFF;
        endcase
      end
    end
  end

  // Output decode of the state being entered, registered alongside it
  always_comb begin
    out_d = decode_outputs(state_d);
  end

  // Timer is loaded on entry to each timed state
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = SETTLE_LOAD;
    if (state_d != state_q) begin
      case (state_d)
        ST_WAKE: begin
          tmr_load_c = 1'b1;
          tmr_val_c  = WAKE_LOAD;
        end
        ST_MUTE, ST_UNMUTE: begin
          tmr_load_c = 1'b1;
          tmr_val_c  = SETTLE_LOAD;
        end
        default: begin
          tmr_load_c = 1'b0;
          tmr_val_c  = SETTLE_LOAD;
        end
      endcase
    end
  end

  amp_ctrl_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load_c),
    .load_val_i (tmr_val_c),
    .done_o     (tmr_done)
  );

  // Idle counter runs only while staying in ACTIVE; activity clears it
  always_comb begin
    idle_d = '0;
    if ((state_q == ST_ACTIVE) && (state_d == ST_ACTIVE) && !activity &&
        (idle_q != IDLE_LAST)) begin
      idle_d = idle_q + CNT_W'(1);
    end
  end

  // Gain and pending register: direct update in OFF, muted/unheard update elsewhere
  always_comb begin
    gain_d     = gain_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    apply_c    = ((state_q == ST_WAKE) && (state_d == ST_ACTIVE) && pend_q) ||
                 ((state_q == ST_MUTE) && (state_d == ST_UNMUTE));
    if (state_q == ST_OFF) begin
      if (wr_acc_c) begin
        gain_d     = sel_c;
        pend_val_d = sel_c;
        pend_d     = 1'b0;
      end
    end else begin
      if (apply_c) begin
        gain_d = pend_val_q;
        pend_d = 1'b0;
      end
      if (wr_acc_c) begin
        pend_d     = 1'b1;
        pend_val_d = sel_c;
      end
    end
  end

  // Datapath registers; reset discards any gain change in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 2'b00;
      idle_q     <= '0;
      gain_q     <= GAIN_0;
      pend_q     <= 1'b0;
      pend_val_q <= GAIN_0;
    end else begin
      run_q      <= {run_q[0], 1'b1};
      idle_q     <= idle_d;
      gain_q     <= gain_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end

  assign GAIN     = gain_q;
  assign SHUTDOWN = out_q.shutdown;
  assign audio_en = out_q.audio_en;
  assign busy     = out_q.busy;

endmodule

// File: tb/tb_amp_power_sequencer.sv
// Directed scenarios plus randomized traffic against a deadline-based reference model.
module tb_amp_power_sequencer;

  localparam int WAKE   = 8;
  localparam int SETTLE = 4;
  localparam int IDLE   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       act = 1'b0;
  logic [1:0] gsel = 2'b00;
  logic       gwr = 1'b0;
  logic [1:0] GAIN;
  logic       SHUTDOWN;
  logic       audio_en;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  amp_power_sequencer #(
    .WAKE_CYCLES   (WAKE),
    .SETTLE_CYCLES (SETTLE),
    .IDLE_CYCLES   (IDLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (en),
    .activity (act),
    .gain_sel (gsel),
    .gain_wr  (gwr),
    .GAIN     (GAIN),
    .SHUTDOWN (SHUTDOWN),
    .audio_en (audio_en),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference model: amplifier mode plus absolute-cycle deadlines
  typedef enum int {M_SLEEP, M_WARMUP, M_PLAY, M_HUSH, M_RESTORE} mode_t;
  mode_t      m_mode;
  int         n_edge;
  int         m_deadline;
  int         m_quiet_from;
  logic [1:0] m_gain;
  logic [1:0] m_pend_val;
  bit         m_pend;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, n_edge);
    end
  endtask

  task automatic model_reset();
    m_mode       = M_SLEEP;
    m_deadline   = 0;
    m_quiet_from = 0;
    m_gain       = 2'b00;
    m_pend_val   = 2'b00;
    m_pend       = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    bit    acc;
    bit    apply;
    mode_t nxt;
    n_edge++;
    acc = gwr && !((gsel == m_gain) && (gsel == m_pend_val));
    nxt = m_mode;
    if (!en) begin
      nxt = M_SLEEP;
    end else begin
      case (m_mode)
        M_SLEEP:   if (act) begin nxt = M_WARMUP; m_deadline = n_edge + WAKE; end
        M_WARMUP:  if (n_edge >= m_deadline) begin nxt = M_PLAY; m_quiet_from = n_edge + 1; end
        M_PLAY: begin
          if (m_pend || acc) begin
            nxt = M_HUSH;
            m_deadline = n_edge + SETTLE;
          end else if (act) begin
            m_quiet_from = n_edge + 1;
          end else if (n_edge - m_quiet_from >= IDLE - 1) begin
            nxt = M_SLEEP;
          end
        end
        M_HUSH:    if (n_edge >= m_deadline) begin nxt = M_RESTORE; m_deadline = n_edge + SETTLE; end
        M_RESTORE: if (n_edge >= m_deadline) begin nxt = M_PLAY; m_quiet_from = n_edge + 1; end
        default:   nxt = M_SLEEP;
      endcase
    end
    if (m_mode == M_SLEEP) begin
      if (acc) begin
        m_gain     = gsel;
        m_pend_val = gsel;
        m_pend     = 1'b0;
      end
    end else begin
      apply = (m_mode == M_WARMUP && nxt == M_PLAY && m_pend) ||
              (m_mode == M_HUSH && nxt == M_RESTORE);
      if (apply) begin
        m_gain = m_pend_val;
        m_pend = 1'b0;
      end
      if (acc) begin
        m_pend     = 1'b1;
        m_pend_val = gsel;
      end
    end
    m_mode = nxt;
  endtask

  // One clock: step the model on the edge, compare all pins shortly after
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_val("SHUTDOWN", 32'(SHUTDOWN), 32'(m_mode != M_SLEEP));
    check_val("audio_en", 32'(audio_en), 32'(m_mode == M_PLAY));
    check_val("busy", 32'(busy), 32'(m_mode == M_WARMUP || m_mode == M_HUSH || m_mode == M_RESTORE));
    check_val("GAIN", 32'(GAIN), 32'(m_gain));
  endtask

  // Asynchronous reset mid-cycle, then a quiet release window
  task automatic do_reset();
    #2;
    rst = 1'b0;
    en  = 1'b0;
    act = 1'b0;
    gwr = 1'b0;
    #1;
    check_val("rst_SHUTDOWN", 32'(SHUTDOWN), 32'd0);
    check_val("rst_audio_en", 32'(audio_en), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_GAIN", 32'(GAIN), 32'd0);
    model_reset();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    cycle();
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit seen;
    n_edge = 0;
    model_reset();

    // Reset state before any edge
    #3;
    check_val("init_SHUTDOWN", 32'(SHUTDOWN), 32'd0);
    check_val("init_audio_en", 32'(audio_en), 32'd0);
    check_val("init_busy", 32'(busy), 32'd0);
    check_val("init_GAIN", 32'(GAIN), 32'd0);
    cycle();
    cycle();

    // Release: a wake request on the first edge after release must be ignored
    rst = 1'b1;
    en  = 1'b1;
    act = 1'b1;
    @(posedge clk);
    #1;
    check_val("sync_hold", 32'(SHUTDOWN), 32'd0);
    en  = 1'b0;
    act = 1'b0;
    cycle();
    cycle();
    cycle();

    // Wake: SHUTDOWN one edge after activity, audio_en WAKE edges later
    en  = 1'b1;
    act = 1'b1;
    cycle();
    act = 1'b0;
    check_val("wake_sd", 32'(SHUTDOWN), 32'd1);
    k = 0;
    while (audio_en !== 1'b1 && k < 40) begin cycle(); k++; end
    check_val("wake_len", 32'(k), 32'(WAKE));

    // Gain change in ACTIVE: mute, settle, load, settle, unmute
    gsel = 2'b10;
    gwr  = 1'b1;
    cycle();
    gwr  = 1'b0;
    check_val("mute_now", 32'(audio_en), 32'd0);
    k = 0;
    while (GAIN !== 2'b10 && k < 40) begin cycle(); k++; end
    check_val("mute_len", 32'(k), 32'(SETTLE));
    k = 0;
    while (audio_en !== 1'b1 && k < 40) begin cycle(); k++; end
    check_val("unmute_len", 32'(k), 32'(SETTLE));

    // Idle expiry with no activity
    k = 0;
    while (SHUTDOWN !== 1'b0 && k < 60) begin cycle(); k++; end
    check_val("idle_len", 32'(k), 32'(IDLE));

    // Activity on the last idle cycle keeps the amplifier running
    act = 1'b1;
    cycle();
    act = 1'b0;
    k = 0;
    while (audio_en !== 1'b1 && k < 40) begin cycle(); k++; end
    check_val("wake_len2", 32'(k), 32'(WAKE));
    for (int i = 0; i < IDLE - 1; i++) cycle();
    act = 1'b1;
    cycle();
    act = 1'b0;
    check_val("idle_saved_sd", 32'(SHUTDOWN), 32'd1);
    check_val("idle_saved_en", 32'(audio_en), 32'd1);
    for (int i = 0; i < 5; i++) cycle();

    // Write in MUTE then in UNMUTE: two gain steps with a one-cycle ACTIVE gap
    gsel = 2'b00;
    gwr  = 1'b1;
    cycle();
    gsel = 2'b01;
    cycle();
    gwr  = 1'b0;
    k = 0;
    while (GAIN !== 2'b01 && k < 40) begin cycle(); k++; end
    check_val("first_gain", 32'(GAIN), 32'd1);
    gsel = 2'b11;
    gwr  = 1'b1;
    cycle();
    gwr  = 1'b0;
    k = 0;
    seen = 1'b0;
    while (GAIN !== 2'b11 && k < 40) begin
      cycle();
      k++;
      if (audio_en === 1'b1) seen = 1'b1;
    end
    check_val("second_gain", 32'(GAIN), 32'd3);
    check_val("active_gap", 32'(seen), 32'd1);
    k = 0;
    while (audio_en !== 1'b1 && k < 40) begin cycle(); k++; end

    // Enable dropped mid-MUTE; the pending code lands at the next wake
    gsel = 2'b00;
    gwr  = 1'b1;
    cycle();
    gwr  = 1'b0;
    cycle();
    cycle();
    en = 1'b0;
    cycle();
    check_val("drop_sd", 32'(SHUTDOWN), 32'd0);
    check_val("drop_gain", 32'(GAIN), 32'd3);
    en  = 1'b1;
    act = 1'b1;
    cycle();
    act = 1'b0;
    k = 0;
    while (audio_en !== 1'b1 && k < 40) begin cycle(); k++; end
    check_val("wake_gain", 32'(GAIN), 32'd0);

    // Direct gain write while OFF
    en = 1'b0;
    cycle();
    gsel = 2'b10;
    gwr  = 1'b1;
    cycle();
    gwr  = 1'b0;
    check_val("off_gain", 32'(GAIN), 32'd2);
    check_val("off_busy", 32'(busy), 32'd0);

    // Reset mid-WAKE
    en  = 1'b1;
    act = 1'b1;
    cycle();
    act = 1'b0;
    cycle();
    cycle();
    cycle();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    check_val("off_after_rst", 32'(SHUTDOWN), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        en   = ($urandom_range(0, 99) < 96);
        act  = ($urandom_range(0, 99) < 9);
        gwr  = ($urandom_range(0, 99) < 5);
        gsel = 2'($urandom_range(0, 3));
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
